vga_playfield_prefetcher: RTL and testbench
===========================================

Name: vga_playfield_prefetcher

Overview:
Parametrised successor to the board-drawing path of the VGA Avalon interface. Instead of reading one board-row word combinationally per pixel, it fetches each playfield row word from the shared dual-port VRAM once per block row, during horizontal blank, into a ping-pong line buffer. It then serves per-pixel cell templates from that buffer with fixed latency. It sits between the VGA controller (DrawX/DrawY, line/frame strobes) and the block ROM / colour stage, and shares VRAM port B with other hardware readers through a busy/stall handshake.

Parameters:
CELL_BITS, 2, bits per board cell (block template width)
BOARD_COLS, 10, cells per board row
BOARD_ROWS, 20, board rows
BLOCK_SHIFT, 4, log2 of block size in pixels (16 px)
TOP_BLK, 5, block-row index of board top edge on screen
LEFT_BLK, 15, block-column index of board left edge on screen
ROW_BASE_ADDR, 2, VRAM word address of board row 0
ADDR_W, 11, VRAM address width
DATA_W, 32, VRAM data width; must be >= CELL_BITS*BOARD_COLS+1 (elaboration error otherwise)
RD_LAT, 1, VRAM read latency in cycles (1..3)

Ports:
CLK  in  1  system clock
RESET_N  in  1  asynchronous active-low reset
line_start  in  1  one-cycle pulse at start of each scanline's horizontal blank
frame_start  in  1  one-cycle pulse at start of vertical blank
DrawX  in  10  current pixel column
DrawY  in  10  current scanline
ram_rd  out  1  read request to VRAM port B
ram_addr  out  ADDR_W  read address
ram_busy  in  1  port B owned by another reader; request not accepted this cycle
ram_rdata  in  DATA_W  read data, valid RD_LAT cycles after an accepted request
cell_template  out  CELL_BITS  template of cell under (DrawX,DrawY), registered
in_board  out  1  registered: pixel lies inside the board rectangle
game_over  out  1  bit [CELL_BITS*BOARD_COLS] of the displayed row word
underrun  out  1  sticky: a row word was not ready at swap time

Behaviour:
- Reset (async, RESET_N=0): FSM=IDLE; ram_rd=0; ram_addr=0; both buffers=0; back_valid=0; cell_template=0; in_board=0; game_over=0; underrun=0.
- Block coordinates: brow=DrawY>>BLOCK_SHIFT, bcol=DrawX>>BLOCK_SHIFT. Board row r is on screen when brow==TOP_BLK+r.
- Fetch trigger: on line_start, if DrawY[BLOCK_SHIFT-1:0] is all ones and brow+1 falls in [TOP_BLK, TOP_BLK+BOARD_ROWS-1], target row r=brow+1-TOP_BLK.
- FSM:
  - IDLE: on trigger, go to REQ.
  - REQ: ram_rd=1, ram_addr=ROW_BASE_ADDR+r. Held while ram_busy=1. Accepted on the first cycle with ram_busy=0, then go to WAIT.
  - WAIT: count RD_LAT cycles, capture ram_rdata into the back buffer, set back_valid=1, go to IDLE.
- Swap: on the line_start where DrawY[BLOCK_SHIFT-1:0]==0 and the row is in the board:
  - if back_valid: front<=back; clear back_valid.
  - else: front<=0 and set underrun.
  - Swap and a new trigger never coincide (different DrawY low bits).
- Trigger arriving while FSM is not IDLE: ignored, underrun set; the in-flight fetch completes normally.
- frame_start clears underrun and back_valid and returns the FSM to IDLE (aborts any fetch). It does not clear front.
- Pixel output, 1-cycle latency from DrawX/DrawY:
  - in_board <= brow and bcol both inside the board.
  - cell_template <= front[c*CELL_BITS +: CELL_BITS] with c=bcol-LEFT_BLK when in_board; 0 (BLACK) otherwise.
  - game_over <= front[CELL_BITS*BOARD_COLS] when in_board; 0 otherwise.
- Column index c is computed in $clog2(BOARD_COLS)+1 bits. No wrap: DrawX outside the board maps to 0.
- Last board row: no trigger for row BOARD_ROWS. The buffer simply stops refreshing.
- At most one VRAM read per block row, i.e. BOARD_ROWS reads per frame.

Decomposition:
- Shared package gets the cell-template typedef (BLACK/DARK/LIGHT/WHITE encoding) and a fetch_state_t enum {IDLE, REQ, WAIT}.
- Board geometry defaults (TOP_BLK, LEFT_BLK, ROW_BASE_ADDR) live as package constants used as parameter defaults.
- One natural sub-module: vga_row_pingpong, holding the front/back registers, back_valid, and the swap/underrun logic.

Test Plan:
1. Default params, ram_busy=0, VRAM row 0 = 32'h000F_FFFF. On the line_start at DrawY=79: ram_rd=1 with ram_addr=2 for one cycle. After the swap at DrawY=80, pixel DrawX=240..255 gives cell_template=3 (1 cycle later) and game_over=0.
2. Row 3 word 32'h0010_0004 (cell1=1, gameover bit 20 set). At DrawY=128, DrawX=256 -> cell_template=1, game_over=1. DrawX=232 -> in_board=0, cell_template=0.
3. ram_busy held high for 5 cycles after the trigger: ram_rd and ram_addr stay stable all 5 cycles. Data is captured RD_LAT cycles after ram_busy falls, and underrun stays 0.
4. ram_busy held high across the swap line_start: front=0 for that row, underrun=1 and remains set until the next frame_start, which clears it.
5. RD_LAT=3, BOARD_COLS=12, DATA_W=32: the capture happens exactly 3 cycles after acceptance, and column 11 reads bits [23:22].
6. RESET_N asserted during WAIT: all outputs go to 0 immediately. After release, no stale capture occurs and the next trigger fetches normally.

Source files
------------

// File: rtl/vga_playfield_prefetcher_pkg.sv
// Shared types and board geometry defaults for the playfield prefetch path.
package vga_playfield_prefetcher_pkg;

   // Cell template encoding consumed by the block ROM / colour stage.
   typedef enum logic [1:0] {
      BLACK = 2'd0,
      DARK  = 2'd1,
      LIGHT = 2'd2,
      WHITE = 2'd3
   } cell_template_t;

   // Row-fetch sequencer states.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2
   } fetch_state_t;

   // Default board placement on screen (in 16 px blocks) and VRAM row base.
   localparam int unsigned DEF_TOP_BLK       = 5;
   localparam int unsigned DEF_LEFT_BLK      = 15;
   localparam int unsigned DEF_ROW_BASE_ADDR = 2;

endpackage

// File: rtl/vga_row_pingpong.sv
// Front/back playfield row buffers: the back buffer is filled by the fetch
// sequencer, the front buffer is what the pixel stage displays.
module vga_row_pingpong #(
   parameter int unsigned ROW_W = 21
) (
   input  logic             CLK,
   input  logic             RESET_N,
   input  logic             frame_start,
   input  logic             capture,
   input  logic [ROW_W-1:0] capture_data,
   input  logic             swap,
   input  logic             overlap,
   output logic [ROW_W-1:0] front,
   output logic             underrun
);

   logic [ROW_W-1:0] back;
   logic             back_valid;

   // Buffer load, swap at block-row boundary, and sticky underrun tracking.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         // NOTE: these are plain registers, not a RAM, so a full async reset is cheap and keeps the display black until the first swap.
         front      <= '0;
         back       <= '0;
         back_valid <= 1'b0;
         underrun   <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments let later statements override earlier ones for the same edge without reading updated values.
         if (swap) begin
            if (back_valid) begin
               front      <= back;
               back_valid <= 1'b0;
            end else begin
               front <= '0;
            end
         end
         if (capture) begin
            back       <= capture_data;
            back_valid <= 1'b1;
         end
         if (frame_start) begin
            back_valid <= 1'b0;
            underrun   <= 1'b0;
         end else if (overlap || (swap && !back_valid)) begin
            underrun <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/vga_playfield_prefetcher.sv
// Prefetches one playfield row word per block row during horizontal blank
// and serves per-pixel cell templates from a ping-pong line buffer.
module vga_playfield_prefetcher
   import vga_playfield_prefetcher_pkg::*;
#(
   parameter int unsigned CELL_BITS     = 2,
   parameter int unsigned BOARD_COLS    = 10,
   parameter int unsigned BOARD_ROWS    = 20,
   parameter int unsigned BLOCK_SHIFT   = 4,
   parameter int unsigned TOP_BLK       = DEF_TOP_BLK,
   parameter int unsigned LEFT_BLK      = DEF_LEFT_BLK,
   parameter int unsigned ROW_BASE_ADDR = DEF_ROW_BASE_ADDR,
   parameter int unsigned ADDR_W        = 11,
   parameter int unsigned DATA_W        = 32,
   parameter int unsigned RD_LAT        = 1
) (
   input  logic                 CLK,
   input  logic                 RESET_N,
   input  logic                 line_start,
   input  logic                 frame_start,
   input  logic [9:0]           DrawX,
   input  logic [9:0]           DrawY,
   output logic                 ram_rd,
   output logic [ADDR_W-1:0]    ram_addr,
   input  logic                 ram_busy,
   input  logic [DATA_W-1:0]    ram_rdata,
   output logic [CELL_BITS-1:0] cell_template,
   output logic                 in_board,
   output logic                 game_over,
   output logic                 underrun
);

   localparam int unsigned ROW_W     = CELL_BITS * BOARD_COLS + 1;
   localparam int unsigned BLK_W     = 10 - BLOCK_SHIFT;
   localparam int unsigned ROW_IDX_W = (BOARD_ROWS > 1) ? $clog2(BOARD_ROWS) : 1;
   localparam int unsigned COL_W     = $clog2(BOARD_COLS) + 1;
   localparam logic [1:0]  LAT       = 2'(RD_LAT);

   generate
      if (DATA_W < ROW_W) begin : g_width_check
         $error("DATA_W must be at least CELL_BITS*BOARD_COLS+1");
      end
      if (RD_LAT < 1 || RD_LAT > 3) begin : g_lat_check
         $error("RD_LAT must be in 1..3");
      end
      if (DATA_W > ROW_W) begin : g_rdata_hi
         logic unused_rdata_hi;
         assign unused_rdata_hi = ^ram_rdata[DATA_W-1:ROW_W];
      end
   endgenerate

   // Sub-block pixel bits of DrawX do not affect cell selection.
   logic unused_drawx_lo;
   assign unused_drawx_lo = ^DrawX[BLOCK_SHIFT-1:0];

   logic [BLK_W-1:0]     brow;
   logic [BLK_W-1:0]     bcol;
   logic [31:0]          brow_next;
   logic                 row_in_board;
   logic                 col_in_board;
   logic                 pix_in;
   logic                 trigger;
   logic                 swap;
   logic [ROW_IDX_W-1:0] target_row;

   fetch_state_t         state;
   fetch_state_t         state_d;
   logic [ROW_IDX_W-1:0] row_q;
   logic [ROW_IDX_W-1:0] row_d;
   logic [1:0]           cnt_q;
   logic [1:0]           cnt_d;
   logic                 capture;
   logic                 overlap;

   logic [ROW_W-1:0]     front;
   logic [COL_W-1:0]     col_idx;
   logic [CELL_BITS-1:0] cell_sel;

   assign brow      = DrawY[9:BLOCK_SHIFT];
   assign bcol      = DrawX[9:BLOCK_SHIFT];
   assign brow_next = 32'(brow) + 32'd1;

   assign row_in_board = (32'(brow) >= TOP_BLK) && (32'(brow) < TOP_BLK + BOARD_ROWS);
   assign col_in_board = (32'(bcol) >= LEFT_BLK) && (32'(bcol) < LEFT_BLK + BOARD_COLS);
   assign pix_in       = row_in_board && col_in_board;

   // Fetch on the last scanline of the block row above a board row; swap on
   // the first scanline of that board row. Never both on one line_start.
   assign trigger    = line_start && (&DrawY[BLOCK_SHIFT-1:0]) &&
                       (brow_next >= TOP_BLK) && (brow_next < TOP_BLK + BOARD_ROWS);
   assign swap       = line_start && (DrawY[BLOCK_SHIFT-1:0] == '0) && row_in_board;
   assign target_row = ROW_IDX_W'(brow_next - TOP_BLK);

   // Fetch sequencer state register.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state <= IDLE;
         row_q <= '0;
         cnt_q <= '0;
      end else begin
         state <= state_d;
         row_q <= row_d;
         cnt_q <= cnt_d;
      end
   end

   // Fetch sequencer next state and VRAM request outputs.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned (which would infer a latch).
      state_d  = state;
      row_d    = row_q;
      cnt_d    = cnt_q;
      ram_rd   = 1'b0;
      ram_addr = '0;
      capture  = 1'b0;
      overlap  = trigger && (state != IDLE);
      case (state)
         IDLE: begin
            if (trigger) begin
               state_d = REQ;
               row_d   = target_row;
            end
         end
         REQ: begin
            ram_rd   = 1'b1;
            ram_addr = ADDR_W'(ROW_BASE_ADDR + 32'(row_q));
            if (!ram_busy) begin
               state_d = WAIT;
               cnt_d   = 2'd1;
            end
         end
         WAIT: begin
            if (cnt_q == LAT) begin
               capture = 1'b1;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + 2'd1;
            end
         end
         default: state_d = IDLE;
      endcase
      // Vertical blank aborts any fetch in progress.
      if (frame_start) begin
         state_d = IDLE;
         capture = 1'b0;
      end
   end

   vga_row_pingpong #(
      .ROW_W (ROW_W)
   ) u_pingpong (
      .CLK          (CLK),
      .RESET_N      (RESET_N),
      .frame_start  (frame_start),
      .capture      (capture),
      .capture_data (ram_rdata[ROW_W-1:0]),
      .swap         (swap),
      .overlap      (overlap),
      .front        (front),
      .underrun     (underrun)
   );

   // Column index within the board; pixels outside map to column 0.
   assign col_idx = pix_in ? COL_W'(32'(bcol) - LEFT_BLK) : '0;

   // Select the cell field of the front row word for the current column.
   always_comb begin
      cell_sel = '0;
      for (int i = 0; i < int'(BOARD_COLS); i++) begin
         if (col_idx == COL_W'(i)) begin
            cell_sel = front[i*CELL_BITS +: CELL_BITS];
         end
      end
   end

   // Registered pixel outputs, one cycle after DrawX/DrawY.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         in_board      <= 1'b0;
         cell_template <= '0;
         game_over     <= 1'b0;
      end else begin
         in_board      <= pix_in;
         cell_template <= pix_in ? cell_sel : CELL_BITS'(BLACK);
         game_over     <= pix_in && front[ROW_W-1];
      end
   end

endmodule

// File: tb/tb_vga_playfield_prefetcher.sv
// Directed bench: a default instance and a 12-column, 3-cycle-latency
// instance share timing inputs, each with its own VRAM latency model.
module tb_vga_playfield_prefetcher;

   logic        CLK = 1'b0;
   logic        RESET_N = 1'b0;
   logic        line_start = 1'b0;
   logic        frame_start = 1'b0;
   logic [9:0]  DrawX = '0;
   logic [9:0]  DrawY = '0;
   logic        ram_busy = 1'b0;

   logic        ram_rd1, ram_rd2;
   logic [10:0] ram_addr1, ram_addr2;
   logic [31:0] ram_rdata1, ram_rdata2;
   logic [1:0]  ct1, ct2;
   logic        ib1, ib2, go1, go2, ur1, ur2;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 CLK = ~CLK;

   vga_playfield_prefetcher u_dut (
      .CLK           (CLK),
      .RESET_N       (RESET_N),
      .line_start    (line_start),
      .frame_start   (frame_start),
      .DrawX         (DrawX),
      .DrawY         (DrawY),
      .ram_rd        (ram_rd1),
      .ram_addr      (ram_addr1),
      .ram_busy      (ram_busy),
      .ram_rdata     (ram_rdata1),
      .cell_template (ct1),
      .in_board      (ib1),
      .game_over     (go1),
      .underrun      (ur1)
   );

   vga_playfield_prefetcher #(
      .BOARD_COLS (12),
      .RD_LAT     (3)
   ) u_dut12 (
      .CLK           (CLK),
      .RESET_N       (RESET_N),
      .line_start    (line_start),
      .frame_start   (frame_start),
      .DrawX         (DrawX),
      .DrawY         (DrawY),
      .ram_rd        (ram_rd2),
      .ram_addr      (ram_addr2),
      .ram_busy      (ram_busy),
      .ram_rdata     (ram_rdata2),
      .cell_template (ct2),
      .in_board      (ib2),
      .game_over     (go2),
      .underrun      (ur2)
   );

   // VRAM model: data is driven only in the single cycle RD_LAT after an
   // accepted request; zero at every other time.
   logic [31:0] mem [0:31];
   logic [2:0]  v1 = '0;
   logic [2:0]  v2 = '0;
   logic [31:0] p1 [3];
   logic [31:0] p2 [3];

   always @(posedge CLK) begin
      v1    <= {v1[1:0], ram_rd1 && !ram_busy};
      p1[0] <= mem[ram_addr1[4:0]];
      p1[1] <= p1[0];
      p1[2] <= p1[1];
      v2    <= {v2[1:0], ram_rd2 && !ram_busy};
      p2[0] <= mem[ram_addr2[4:0]];
      p2[1] <= p2[0];
      p2[2] <= p2[1];
   end

   assign ram_rdata1 = v1[0] ? p1[0] : 32'h0;
   assign ram_rdata2 = v2[2] ? p2[2] : 32'h0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic line(input logic [9:0] y);
      DrawY      = y;
      line_start = 1'b1;
      tick();
      line_start = 1'b0;
   endtask

   task automatic frame();
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
   endtask

   task automatic pix(input logic [9:0] x, input logic [9:0] y);
      DrawX = x;
      DrawY = y;
      tick();
   endtask

   initial begin
      for (int i = 0; i < 32; i++) mem[i] = 32'h0;
      mem[2] = 32'h008F_FFFF;  // row 0: all cells 3; 12-col col11 = 2
      mem[5] = 32'h0010_0004;  // row 3: cell1 = 1, 10-col game-over bit set
      mem[6] = 32'h0000_0002;  // row 4: cell0 = 2
      mem[7] = 32'h0000_0003;  // row 5: cell0 = 3

      // Reset state
      DrawX = 10'd240;
      DrawY = 10'd80;
      tick();
      tick();
      check("rst_ram_rd",   ram_rd1, 0);
      check("rst_ram_addr", ram_addr1, 0);
      check("rst_cell",     ct1, 0);
      check("rst_in_board", ib1, 0);
      check("rst_game_over", go1, 0);
      check("rst_underrun", ur1, 0);
      RESET_N = 1'b1;
      tick();
      frame();

      // Test 1: row 0 fetch at DrawY=79, swap at 80
      line(10'd79);
      check("t1_rd",     ram_rd1, 1);
      check("t1_addr",   ram_addr1, 2);
      check("t1_rd12",   ram_rd2, 1);
      check("t1_addr12", ram_addr2, 2);
      tick();
      check("t1_rd_one_cycle", ram_rd1, 0);
      repeat (5) tick();
      line(10'd80);
      pix(10'd240, 10'd80);
      check("t1_cell_240", ct1, 3);
      check("t1_go_240",   go1, 0);
      check("t1_ib_240",   ib1, 1);
      check("t1_cell12_240", ct2, 3);
      pix(10'd255, 10'd80);
      check("t1_cell_255", ct1, 3);
      // Test 5: 12-column instance, column 11 reads bits [23:22]
      pix(10'd416, 10'd80);
      check("t5_cell12_col11", ct2, 2);
      check("t5_go12",         go2, 0);
      check("t5_ib_outside",   ib1, 0);
      check("t5_cell_outside", ct1, 0);
      check("t1_underrun",   ur1, 0);
      check("t5_underrun12", ur2, 0);

      // Test 2: row 3 with game-over bit
      line(10'd127);
      check("t2_addr", ram_addr1, 5);
      repeat (5) tick();
      line(10'd128);
      pix(10'd256, 10'd128);
      check("t2_cell_256", ct1, 1);
      check("t2_go_256",   go1, 1);
      check("t2_ib_256",   ib1, 1);
      check("t2_cell12_256", ct2, 1);
      check("t2_go12_256",   go2, 0);
      pix(10'd232, 10'd128);
      check("t2_ib_232",   ib1, 0);
      check("t2_cell_232", ct1, 0);
      check("t2_go_232",   go1, 0);

      // Test 3: busy for several cycles after trigger
      ram_busy = 1'b1;
      line(10'd143);
      for (int i = 0; i < 5; i++) begin
         check("t3_busy_rd",   ram_rd1, 1);
         check("t3_busy_addr", ram_addr1, 6);
         check("t3_busy_rd12", ram_rd2, 1);
         tick();
      end
      ram_busy = 1'b0;
      tick();
      check("t3_rd_released", ram_rd1, 0);
      repeat (5) tick();
      line(10'd144);
      pix(10'd240, 10'd144);
      check("t3_cell",     ct1, 2);
      check("t3_cell12",   ct2, 2);
      check("t3_underrun", ur1, 0);
      check("t3_underrun12", ur2, 0);

      // Test 6: reset asserted while fetches are in WAIT
      line(10'd79);
      DrawX = 10'd240;
      DrawY = 10'd144;
      tick();
      check("t6_pre_ib12",   ib2, 1);
      check("t6_pre_cell12", ct2, 2);
      #2 RESET_N = 1'b0;
      #1;
      check("t6_rst_rd12",   ram_rd2, 0);
      check("t6_rst_addr12", ram_addr2, 0);
      check("t6_rst_cell12", ct2, 0);
      check("t6_rst_ib12",   ib2, 0);
      check("t6_rst_go12",   go2, 0);
      check("t6_rst_ur12",   ur2, 0);
      check("t6_rst_cell",   ct1, 0);
      check("t6_rst_ib",     ib1, 0);
      tick();
      tick();
      RESET_N = 1'b1;
      repeat (4) tick();
      line(10'd80);
      check("t6_no_stale_ur",   ur1, 1);
      check("t6_no_stale_ur12", ur2, 1);
      pix(10'd240, 10'd80);
      check("t6_no_stale_cell",   ct1, 0);
      check("t6_no_stale_cell12", ct2, 0);
      frame();
      check("t6_frame_clears_ur", ur1, 0);
      line(10'd79);
      check("t6_refetch_rd",   ram_rd1, 1);
      check("t6_refetch_addr", ram_addr1, 2);
      repeat (5) tick();
      line(10'd80);
      pix(10'd240, 10'd80);
      check("t6_refetch_cell", ct1, 3);
      pix(10'd416, 10'd80);
      check("t6_refetch_cell12", ct2, 2);
      check("t6_refetch_ur", ur1, 0);

      // Test 4: busy across the swap -> underrun until frame_start
      ram_busy = 1'b1;
      line(10'd159);
      check("t4_addr", ram_addr1, 7);
      repeat (3) tick();
      line(10'd160);
      check("t4_underrun",   ur1, 1);
      check("t4_underrun12", ur2, 1);
      pix(10'd240, 10'd160);
      check("t4_cell_black", ct1, 0);
      check("t4_ib",         ib1, 1);
      ram_busy = 1'b0;
      repeat (6) tick();
      check("t4_underrun_sticky", ur1, 1);
      frame();
      check("t4_frame_clear",   ur1, 0);
      check("t4_frame_clear12", ur2, 0);

      // Boundaries: last board row fetches, nothing beyond or above it
      line(10'd383);
      check("bnd_last_rd",   ram_rd1, 1);
      check("bnd_last_addr", ram_addr1, 21);
      repeat (5) tick();
      line(10'd399);
      check("bnd_past_rd", ram_rd1, 0);
      line(10'd63);
      check("bnd_above_rd", ram_rd1, 0);
      tick();
      check("bnd_underrun", ur1, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
